// File: rtl/audio_peak_follower_pkg.sv
// Shared types for the audio peak follower and the pixel shaders that read its levels.
// Magnitudes are 15-bit unsigned; the published peak word is 16 bits with bit 15 tied low.
package audio_peak_follower_pkg;

  localparam int MAG_W = 15;
  localparam int OUT_W = 16;

  typedef logic [15:0]      audio_t;
  typedef logic [OUT_W-1:0] peak_t;
  typedef logic [MAG_W-1:0] mag_t;

  localparam mag_t MAG_MAX = '1;

  // Strobe and frame pulses travel together so they stay aligned with stage-1 data.
  typedef struct packed {
    logic strobe;
    logic frame;
  } ctrl_t;

  // Width of a counter that must hold the value 'frames' (at least one bit).
  function automatic int hold_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/audio_peak_follower_if.sv
// Sample/frame input bundle and peak output bundle of the audio peak follower.
// The master side is the codec/timing source; the slave side is the follower itself.
interface audio_peak_follower_if #(
  parameter int SAMPLE_W = 16
);

  logic                iSTROBE;
  logic [SAMPLE_W-1:0] iL;
  logic [SAMPLE_W-1:0] iR;
  logic                iFRAME;
  logic [15:0]         oL;
  logic [15:0]         oR;
  logic                oUPDATE;

  modport master (
    output iSTROBE, iL, iR, iFRAME,
    input  oL, oR, oUPDATE
  );

  modport slave (
    input  iSTROBE, iL, iR, iFRAME,
    output oL, oR, oUPDATE
  );

endinterface

// File: rtl/audio_peak_channel.sv
// One audio channel: registered abs/saturate, then peak accumulator with hold and decay.
// The output register only loads on a frame pulse so shaders never see a mid-frame change.
module audio_peak_channel
  import audio_peak_follower_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                strobe_dly,
  input  logic                frame_dly,
  output peak_t               peak
);

  localparam int EXT_W  = (SAMPLE_W + 1 > MAG_W) ? SAMPLE_W + 1 : MAG_W;
  localparam int HOLD_W = hold_width(HOLD_FRAMES);

  typedef logic [HOLD_W-1:0] hold_t;

  localparam hold_t HOLD_LOAD = hold_t'(HOLD_FRAMES);

  logic [SAMPLE_W:0] sample_ext;
  logic [SAMPLE_W:0] abs_val;
  logic [EXT_W-1:0]  abs_ext;

  mag_t  mag_d, mag_q;
  mag_t  acc_d, acc_q;
  mag_t  out_d, out_q;
  hold_t hold_d, hold_q;

  mag_t  decay_step;
  mag_t  acc_decayed;
  hold_t hold_decayed;
  mag_t  frame_peak;
  logic  is_new;

  // One extra bit so the magnitude of the most negative sample is representable.
  always_comb begin
    sample_ext = {sample[SAMPLE_W-1], sample};
    abs_val    = sample_ext[SAMPLE_W] ? (~sample_ext + (SAMPLE_W + 1)'(1)) : sample_ext;
    abs_ext    = EXT_W'(abs_val);
    mag_d      = (abs_ext > EXT_W'(MAG_MAX)) ? MAG_MAX : abs_ext[MAG_W-1:0];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    acc_d  = acc_q;
    hold_d = hold_q;
    out_d  = out_q;

    is_new     = strobe_dly && (mag_q > acc_q);
    frame_peak = is_new ? mag_q : acc_q;

    decay_step = acc_q >> DECAY_SHIFT;
    if (decay_step == '0) begin
      decay_step = (acc_q != '0) ? mag_t'(1) : '0;
    end

    if (hold_q != '0) begin
      hold_decayed = hold_q - hold_t'(1);
      acc_decayed  = acc_q;
    end else begin
      hold_decayed = '0;
      acc_decayed  = acc_q - decay_step;
    end

    if (frame_dly) begin
      out_d  = frame_peak;
      acc_d  = (strobe_dly && (mag_q > acc_decayed)) ? mag_q : acc_decayed;
      hold_d = is_new ? HOLD_LOAD : hold_decayed;
    end else if (is_new) begin
      acc_d  = mag_q;
      hold_d = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (!rst_n) begin
      mag_q  <= '0;
      acc_q  <= '0;
      hold_q <= '0;
      out_q  <= '0;
    end else begin
      mag_q  <= mag_d;
      acc_q  <= acc_d;
      hold_q <= hold_d;
      out_q  <= out_d;
    end
  end

  assign peak = {1'b0, out_q};

endmodule

// File: rtl/audio_peak_follower.sv
// Stereo peak follower: delays strobe/frame alongside the per-channel magnitude stage
// and publishes both peaks with a one-cycle update pulse two clocks after frame start.
module audio_peak_follower
  import audio_peak_follower_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  audio_peak_follower_if.slave  bus
);

  ctrl_t ctrl_d, ctrl_q;
  logic  update_d, update_q;
  peak_t peak_l, peak_r;

  always_comb begin
    ctrl_d.strobe = bus.iSTROBE;
    ctrl_d.frame  = bus.iFRAME;
    update_d      = ctrl_q.frame;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      ctrl_q   <= '0;
      update_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      update_q <= update_d;
    end
  end

  audio_peak_channel #(
    .SAMPLE_W    (SAMPLE_W),
    .DECAY_SHIFT (DECAY_SHIFT),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_left (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .sample     (bus.iL),
    .strobe_dly (ctrl_q.strobe),
    .frame_dly  (ctrl_q.frame),
    .peak       (peak_l)
  );

  audio_peak_channel #(
    .SAMPLE_W    (SAMPLE_W),
    .DECAY_SHIFT (DECAY_SHIFT),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_right (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .sample     (bus.iR),
    .strobe_dly (ctrl_q.strobe),
    .frame_dly  (ctrl_q.frame),
    .peak       (peak_r)
  );

  assign bus.oL      = peak_l;
  assign bus.oR      = peak_r;
  assign bus.oUPDATE = update_q;

endmodule

// File: tb/tb_audio_peak_follower.sv
// Directed bench for audio_peak_follower (HOLD_FRAMES=2, DECAY_SHIFT=4): a vector
// table for magnitude/saturation plus hand-written hold, decay, coincidence and reset sequences.
module tb_audio_peak_follower;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  audio_peak_follower_if #(.SAMPLE_W(16)) bus ();

  audio_peak_follower #(
    .SAMPLE_W    (16),
    .DECAY_SHIFT (4),
    .HOLD_FRAMES (2)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_hold  [6];
  logic [15:0] exp_small [9];
  logic [15:0] exp_coinc [4];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%04h), expected %0d (0x%04h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one cycle of inputs, step past the rising edge, then drop the pulses.
  task automatic drive(input logic rst, input logic s, input logic f,
                       input logic [15:0] l, input logic [15:0] r);
    rst_n       = rst;
    bus.iSTROBE = s;
    bus.iFRAME  = f;
    bus.iL      = l;
    bus.iR      = r;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.iSTROBE = 1'b0;
    bus.iFRAME  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    drive(1'b1, 1'b1, 1'b0, l, r);
  endtask

  // Frame pulse, then read the latched peaks two edges after the pulse was sampled.
  task automatic frame_read(input string tag, input logic [15:0] el, input logic [15:0] er);
    drive(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    check({tag, "_early_upd"}, {15'd0, bus.oUPDATE}, 16'd0);
    idle();
    check({tag, "_oL"}, bus.oL, el);
    check({tag, "_oR"}, bus.oR, er);
    check({tag, "_upd"}, {15'd0, bus.oUPDATE}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[1] = '{16'hFC18, 16'h01F4, 16'd1000, 16'd500};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'd0,    16'd1};
    vecs[3] = '{16'h8001, 16'h0001, 16'h7FFF, 16'd1};
    vecs[4] = '{16'h1234, 16'hEDCC, 16'h1234, 16'h1234};
    vecs[5] = '{16'hFFFF, 16'h8000, 16'd1,    16'h7FFF};

    exp_hold  = '{16'd1600, 16'd1600, 16'd1600, 16'd1500, 16'd1407, 16'd1320};
    exp_small = '{16'd5, 16'd5, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    exp_coinc = '{16'd200, 16'd200, 16'd200, 16'd188};

    rst_n       = 1'b0;
    bus.iSTROBE = 1'b0;
    bus.iFRAME  = 1'b0;
    bus.iL      = 16'h0000;
    bus.iR      = 16'h0000;

    // Reset held three cycles while strobes and frames toggle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], ~i[0], 16'h8000, 16'h7FFF);
      check($sformatf("reset%0d_oL", i), bus.oL, 16'd0);
      check($sformatf("reset%0d_oR", i), bus.oR, 16'd0);
      check($sformatf("reset%0d_upd", i), {15'd0, bus.oUPDATE}, 16'd0);
    end

    // Magnitude and saturation table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      strobe(vecs[i].l, vecs[i].r);
      frame_read($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
      idle();
      check($sformatf("vec%0d_upd_pulse", i), {15'd0, bus.oUPDATE}, 16'd0);
    end

    // Hold for two frames, then decay by acc>>4.
    do_reset();
    strobe(16'd1600, 16'd0);
    for (int i = 0; i < 6; i++) begin
      frame_read($sformatf("hold%0d", i), exp_hold[i], 16'd0);
    end

    // Back-to-back frame pulses: one latch and one hold/decay step each.
    do_reset();
    strobe(16'd1600, 16'd0);
    drive(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
    check("b2b_first_upd", {15'd0, bus.oUPDATE}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
      check($sformatf("b2b%0d_oL", i), bus.oL, exp_hold[i]);
      check($sformatf("b2b%0d_upd", i), {15'd0, bus.oUPDATE}, 16'd1);
    end
    idle();
    check("b2b4_oL", bus.oL, 16'd1407);
    check("b2b4_upd", {15'd0, bus.oUPDATE}, 16'd1);
    idle();
    check("b2b_end_upd", {15'd0, bus.oUPDATE}, 16'd0);

    // Strobe coincident with frame: new sample latched, hold reloaded.
    do_reset();
    strobe(16'd100, 16'd0);
    drive(1'b1, 1'b1, 1'b1, 16'd200, 16'd0);
    idle();
    check("coinc_oL", bus.oL, 16'd200);
    check("coinc_upd", {15'd0, bus.oUPDATE}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      frame_read($sformatf("coinc%0d", i), exp_coinc[i], 16'd0);
    end

    // Small value decays by one per frame and saturates at zero.
    do_reset();
    strobe(16'd5, 16'd0);
    for (int i = 0; i < 9; i++) begin
      frame_read($sformatf("small%0d", i), exp_small[i], 16'd0);
    end

    // Reset pulse between strobe and frame discards the sample.
    do_reset();
    strobe(16'd1000, 16'd2000);
    do_reset();
    frame_read("rst_mid", 16'd0, 16'd0);

    // Reset in the same cycle as strobe and frame overrides both.
    do_reset();
    strobe(16'd1000, 16'd1000);
    idle();
    drive(1'b0, 1'b1, 1'b1, 16'd3000, 16'd3000);
    idle();
    check("rst_ovr_upd", {15'd0, bus.oUPDATE}, 16'd0);
    check("rst_ovr_oL", bus.oL, 16'd0);
    frame_read("rst_ovr", 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
